cbus_ram_ctrl: RTL and testbench
================================

Name: cbus_ram_ctrl

Overview:
- Bridges a cache-bus style burst request port onto one single-port RAM port: address, enable, byte strobe, write data and read data.
- Sits between the cache/bus arbiter (upstream) and the single-port RAM (downstream).
- Generates per-beat RAM addresses for incrementing bursts.
- Tracks the RAM's fixed read latency so read data is returned with correct ready/last timing.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 64, bits per RAM word / bus beat.
- BYTE_WIDTH, 8, bits per strobe lane; BPW = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, RAM read latency in cycles (0..4); must match the attached RAM.
- LEN_WIDTH, 4, width of burst length field (beats-1).

Ports:
- clk, in, 1, clock.
- resetn, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present; held high until the last beat's response.
- req_is_write, in, 1, 1 = write burst, 0 = read burst; stable while req_valid.
- req_addr, in, ADDR_WIDTH, burst start word address; stable while req_valid.
- req_len, in, LEN_WIDTH, number of beats minus 1; stable while req_valid.
- req_strobe, in, BPW, write byte-lane enables for the current beat.
- req_data, in, DATA_WIDTH, write data for the current beat; requester advances it after each resp_ready.
- resp_ready, out, 1, one beat completed (write accepted or read data valid).
- resp_last, out, 1, qualifies the final beat; only high with resp_ready.
- resp_data, out, DATA_WIDTH, read data; don't-care on writes.
- ram_en, out, 1, RAM port enable.
- ram_addr, out, ADDR_WIDTH, RAM word address.
- ram_strobe, out, BPW, RAM byte write enables; all zero on reads.
- ram_wdata, out, DATA_WIDTH, RAM write data.
- ram_rdata, in, DATA_WIDTH, RAM read data, valid READ_LATENCY cycles after ram_en.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, beat counters 0, latency pipeline cleared. Outputs resp_ready=0, resp_last=0, ram_en=0, ram_strobe=0, ram_addr=0.
- Reset mid-burst aborts the burst immediately, with no further RAM activity. RAM contents are not the controller's concern.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - No RAM activity.
  - On req_valid=1: latch addr/len, clear issue and return counters, enter WRITE or READ per req_is_write.
  - First RAM access is the cycle after acceptance.
- WRITE, one beat per cycle:
  - Outputs: ram_en=1, ram_addr=base+beat (mod 2**ADDR_WIDTH), ram_strobe=req_strobe, ram_wdata=req_data.
  - resp_ready=1 combinationally the same cycle; resp_last=1 when beat==len.
  - On the last beat go to DONE.
  - A strobe of all zeros is legal: RAM enabled, no bytes modified.
- READ, issue phase:
  - While issued <= len: ram_en=1, ram_strobe=0, ram_addr=base+issued; issued increments each cycle.
  - After len+1 issues: ram_en=0.
- READ, return phase:
  - A READ_LATENCY-deep valid shift register tracks issued beats.
  - resp_ready = its output (for READ_LATENCY=0, resp_ready = issue strobe, same cycle); resp_data = ram_rdata.
  - resp_last when returned==len. Go to DONE on that beat.
  - Total read burst duration = len+1+READ_LATENCY cycles after acceptance.
- DONE: exactly one cycle, req_valid ignored (requester drops it here), then IDLE. Back-to-back bursts therefore have a 2-cycle gap: DONE, then IDLE acceptance.
- No backpressure on responses; the requester must accept every resp_ready beat.
- Counters are LEN_WIDTH+1 bits so len = all-ones (16 beats at default) does not overflow.
- Address wrap: a burst crossing 2**ADDR_WIDTH-1 continues at 0.
- Changes to req_is_write/req_addr/req_len while in WRITE/READ are ignored; latched values are used.

Test Plan:
- Single write, len=0, addr=5, strobe=0xFF, data=0x1122334455667788 -> one cycle with ram_en=1, ram_addr=5, ram_strobe=0xFF, resp_ready=resp_last=1; DONE next cycle, then IDLE.
- 4-beat write at addr=8, strobes 0xFF,0x0F,0xF0,0x00, data D0..D3 -> ram_addr 8,9,10,11 on consecutive cycles with matching strobes; resp_last only on beat 3.
- 4-beat read at addr=8, READ_LATENCY=1 after the above write -> first resp_ready 2 cycles after acceptance. Returned words are: beat 0 = D0; beat 1 = low 4 bytes from D1, high bytes 0; beat 2 = high bytes from D2, low bytes 0; beat 3 = 0. resp_last on beat 3; 6 cycles from acceptance to DONE.
- Repeat the read with READ_LATENCY=0 and READ_LATENCY=3 -> same data. First response 1 and 4 cycles after acceptance respectively; no gaps between beats.
- Read len=3 at addr=2**ADDR_WIDTH-2 -> ram_addr sequence 1022,1023,0,1 (default); 4 responses.
- Assert resetn low during beat 2 of an 8-beat write -> same-cycle ram_en=0, resp_ready=0, state IDLE. After release a new read of len=0 is accepted normally and returns the beats written before the reset.

Source files
------------

// File: rtl/cbus_ram_ctrl.sv
// Cache-bus burst to single-port RAM bridge: first RAM access the cycle after acceptance,
// writes complete one beat per cycle, reads return READ_LATENCY cycles after issue; no response backpressure.
module cbus_ram_ctrl #(
   parameter int  ADDR_WIDTH   = 10,
   parameter int  DATA_WIDTH   = 64,
   parameter int  BYTE_WIDTH   = 8,
   parameter int  READ_LATENCY = 1,
   parameter int  LEN_WIDTH    = 4,
   localparam int BPW          = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   input  logic                  req_is_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic [BPW-1:0]        req_strobe,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  resp_ready,
   output logic                  resp_last,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [BPW-1:0]        ram_strobe,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int CW = LEN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic [LEN_WIDTH-1:0]  len;
   logic [CW-1:0]         issued, returned;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic                  issue_vld, ret_vld, ret_last;

   // counters carry one extra bit so an all-ones length still terminates
   assign beat_addr = base + ADDR_WIDTH'(issued);
   assign issue_vld = (state == READ) && (issued <= {1'b0, len});
   assign ret_last  = ret_vld && (returned == {1'b0, len});
   assign resp_data = ram_rdata;
   assign ram_wdata = req_data;

   generate
      if (READ_LATENCY == 0) begin : g_lat0
         assign ret_vld = issue_vld;
      end else begin : g_latn
         logic [READ_LATENCY-1:0] vld_pipe;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               vld_pipe <= '0;
            end else if (state == READ) begin
               vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(issue_vld);
            end else begin
               vld_pipe <= '0;
            end
         end
         assign ret_vld = vld_pipe[READ_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         base     <= '0;
         len      <= '0;
         issued   <= '0;
         returned <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  base     <= req_addr;
                  len      <= req_len;
                  issued   <= '0;
                  returned <= '0;
               end
            end
            WRITE: issued <= issued + CW'(1);
            READ: begin
               if (issue_vld) issued <= issued + CW'(1);
               if (ret_vld) returned <= returned + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      resp_ready = 1'b0;
      resp_last  = 1'b0;
      ram_en     = 1'b0;
      ram_addr   = '0;
      ram_strobe = '0;
      case (state)
         IDLE: begin
            if (req_valid) state_nxt = req_is_write ? WRITE : READ;
         end
         WRITE: begin
            ram_en     = 1'b1;
            ram_addr   = beat_addr;
            ram_strobe = req_strobe;
            resp_ready = 1'b1;
            resp_last  = (issued == {1'b0, len});
            if (resp_last) state_nxt = DONE;
         end
         READ: begin
            ram_en     = issue_vld;
            ram_addr   = issue_vld ? beat_addr : '0;
            resp_ready = ret_vld;
            resp_last  = ret_last;
            if (ret_last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cbus_ram_ctrl.sv
// Drives three controllers (read latency 0, 1, 3) in lockstep against behavioural RAMs
// and a cycle-schedule model of each burst.
module tb_cbus_ram_ctrl;
   localparam int AW    = 10;
   localparam int DW    = 64;
   localparam int BW    = 8;
   localparam int BPW   = DW / BW;
   localparam int LW    = 4;
   localparam int NI    = 3;
   localparam int DEPTH = 1 << AW;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic [NI-1:0]          req_valid;
   logic                   req_is_write;
   logic [AW-1:0]          req_addr;
   logic [LW-1:0]          req_len;
   logic [BPW-1:0]         req_strobe;
   logic [DW-1:0]          req_data;
   logic [NI-1:0]          resp_ready, resp_last, ram_en;
   logic [NI-1:0][DW-1:0]  resp_data, ram_wdata;
   logic [NI-1:0][AW-1:0]  ram_addr;
   logic [NI-1:0][BPW-1:0] ram_strobe;

   // expected outputs for the current cycle, per instance
   logic [NI-1:0]          e_en, e_rdy, e_last, e_rchk, e_wchk;
   logic [NI-1:0][AW-1:0]  e_addr;
   logic [NI-1:0][BPW-1:0] e_strb;
   logic [NI-1:0][DW-1:0]  e_wdata, e_rdata;
   bit                     chk_on, e_full;
   int                     cur_c, burst_id;
   int                     tests = 0;
   int                     fails = 0;
   int                     first_rdy [NI];
   int                     last_at [NI];
   logic [DW-1:0]          shadow [DEPTH];
   logic [BPW-1:0]         bs_strb [16];
   logic [DW-1:0]          bs_data [16];

   always #5 clk = ~clk;

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
      logic [DW-1:0] mem [DEPTH] = '{default: '0};
      logic [DW-1:0] rpipe [4];
      logic [DW-1:0] rdata;

      cbus_ram_ctrl #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
         .READ_LATENCY(LAT), .LEN_WIDTH(LW)
      ) dut (
         .clk(clk), .resetn(resetn),
         .req_valid(req_valid[g]), .req_is_write(req_is_write),
         .req_addr(req_addr), .req_len(req_len),
         .req_strobe(req_strobe), .req_data(req_data),
         .resp_ready(resp_ready[g]), .resp_last(resp_last[g]), .resp_data(resp_data[g]),
         .ram_en(ram_en[g]), .ram_addr(ram_addr[g]), .ram_strobe(ram_strobe[g]),
         .ram_wdata(ram_wdata[g]), .ram_rdata(rdata)
      );

      always @(posedge clk) begin
         if (ram_en[g]) begin
            for (int b = 0; b < BPW; b++)
               if (ram_strobe[g][b]) mem[ram_addr[g]][b*BW +: BW] <= ram_wdata[g][b*BW +: BW];
         end
         rpipe[0] <= mem[ram_addr[g]];
         for (int s = 1; s < 4; s++) rpipe[s] <= rpipe[s-1];
      end

      if (LAT == 0) begin : g_comb
         assign rdata = mem[ram_addr[g]];
      end else begin : g_reg
         assign rdata = rpipe[LAT-1];
      end
   end

   task automatic chk(input string nm, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d burst %0d cyc %0d: got %h, want %h", nm, i, burst_id, cur_c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < NI; i++) begin
            if (cur_c == 0) begin
               first_rdy[i] = -1;
               last_at[i]   = -1;
            end
            if (resp_ready[i] && first_rdy[i] < 0) first_rdy[i] = cur_c;
            if (resp_last[i]) last_at[i] = cur_c;
            chk("ram_en", i, DW'(ram_en[i]), DW'(e_en[i]));
            chk("resp_ready", i, DW'(resp_ready[i]), DW'(e_rdy[i]));
            chk("resp_last", i, DW'(resp_last[i]), DW'(e_last[i]));
            if (e_en[i] || e_full) begin
               chk("ram_addr", i, DW'(ram_addr[i]), DW'(e_addr[i]));
               chk("ram_strobe", i, DW'(ram_strobe[i]), DW'(e_strb[i]));
            end
            if (e_wchk[i]) chk("ram_wdata", i, ram_wdata[i], e_wdata[i]);
            if (e_rchk[i]) chk("resp_data", i, resp_data[i], e_rdata[i]);
         end
      end
   end

   // Burst cycle c=0 is the acceptance cycle; beat k is issued in cycle 1+k and a read
   // beat returns in cycle 1+k+latency. abort_c >= 0 pulls resetn low during that cycle.
   task automatic run_burst(input bit wr, input int a, input int len, input int abort_c);
      int  k, lat, t_last;
      bit  aborted;
      burst_id++;
      if (wr) begin
         for (int j = 0; j <= len; j++)
            if (abort_c < 0 || 1 + j < abort_c)
               for (int b = 0; b < BPW; b++)
                  if (bs_strb[j][b]) shadow[(a + j) % DEPTH][b*BW +: BW] = bs_data[j][b*BW +: BW];
      end
      for (int c = 0; c <= len + 6; c++) begin
         @(posedge clk);
         #1;
         cur_c   = c;
         aborted = (abort_c >= 0) && (c >= abort_c);
         resetn  = !((abort_c >= 0) && (c == abort_c));
         e_full  = !resetn;
         k = (c < 1) ? 0 : ((c - 1 > len) ? len : c - 1);
         req_is_write = wr;
         req_addr     = AW'(a);
         req_len      = LW'(len);
         req_strobe   = bs_strb[k];
         req_data     = bs_data[k];
         for (int i = 0; i < NI; i++) begin
            lat    = lat_of(i);
            t_last = wr ? len + 1 : len + 1 + lat;
            req_valid[i] = !aborted && (c <= t_last);
            e_en[i] = 1'b0; e_rdy[i] = 1'b0; e_last[i] = 1'b0;
            e_rchk[i] = 1'b0; e_wchk[i] = 1'b0;
            e_addr[i] = '0; e_strb[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
            if (!aborted) begin
               if (c >= 1 && c <= len + 1) begin
                  e_en[i]   = 1'b1;
                  e_addr[i] = AW'((a + c - 1) % DEPTH);
                  if (wr) begin
                     e_strb[i]  = bs_strb[c-1];
                     e_wchk[i]  = 1'b1;
                     e_wdata[i] = bs_data[c-1];
                     e_rdy[i]   = 1'b1;
                     e_last[i]  = (c - 1 == len);
                  end
               end
               if (!wr && c >= 1 + lat && c <= len + 1 + lat) begin
                  e_rdy[i]   = 1'b1;
                  e_last[i]  = (c - 1 - lat == len);
                  e_rchk[i]  = 1'b1;
                  e_rdata[i] = shadow[(a + c - 1 - lat) % DEPTH];
               end
            end
         end
      end
   endtask

   task automatic rand_beats(input int len);
      for (int j = 0; j <= len; j++) begin
         case ($urandom_range(0, 5))
            0:       bs_strb[j] = '0;
            1:       bs_strb[j] = '1;
            default: bs_strb[j] = BPW'($urandom_range(0, 255));
         endcase
         bs_data[j] = {$urandom, $urandom};
      end
   endtask

   initial begin
      int a, len;
      resetn = 1'b0;
      req_valid = '0; req_is_write = 1'b0; req_addr = '0; req_len = '0;
      req_strobe = '0; req_data = '0;
      e_en = '0; e_rdy = '0; e_last = '0; e_rchk = '0; e_wchk = '0;
      e_addr = '0; e_strb = '0; e_wdata = '0; e_rdata = '0;
      e_full = 1'b1; cur_c = -1; burst_id = 0;
      for (int j = 0; j < DEPTH; j++) shadow[j] = '0;
      for (int j = 0; j < 16; j++) begin bs_strb[j] = '0; bs_data[j] = '0; end
      chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      e_full = 1'b0;
      @(posedge clk);

      bs_strb[0] = 8'hFF; bs_data[0] = 64'h1122334455667788;
      run_burst(1'b1, 5, 0, -1);
      chk("model_w5", 0, shadow[5], 64'h1122334455667788);

      bs_strb[0] = 8'hFF; bs_data[0] = 64'h0123456789ABCDEF;
      bs_strb[1] = 8'h0F; bs_data[1] = 64'hFEDCBA9876543210;
      bs_strb[2] = 8'hF0; bs_data[2] = 64'hA5A5A5A55A5A5A5A;
      bs_strb[3] = 8'h00; bs_data[3] = 64'hDEADBEEFCAFEF00D;
      run_burst(1'b1, 8, 3, -1);
      chk("model_w8", 0, shadow[8], 64'h0123456789ABCDEF);
      chk("model_w9", 0, shadow[9], 64'h0000000076543210);
      chk("model_w10", 0, shadow[10], 64'hA5A5A5A500000000);
      chk("model_w11", 0, shadow[11], 64'h0);

      run_burst(1'b0, 8, 3, -1);
      for (int i = 0; i < NI; i++) begin
         chk("first_resp_cycle", i, DW'(first_rdy[i]), DW'(1 + lat_of(i)));
         chk("last_resp_cycle", i, DW'(last_at[i]), DW'(4 + lat_of(i)));
      end
      chk("first_resp_lat1", 1, DW'(first_rdy[1]), DW'(2));
      chk("last_resp_lat1", 1, DW'(last_at[1]), DW'(5));

      rand_beats(3);
      run_burst(1'b1, DEPTH - 2, 3, -1);
      run_burst(1'b0, DEPTH - 2, 3, -1);
      chk("wrap_resp_count", 2, DW'(last_at[2] - first_rdy[2] + 1), DW'(4));

      rand_beats(7);
      run_burst(1'b1, 100, 7, 3);
      chk("model_abort_b1", 0, shadow[101], bs_data[1] & {{8{bs_strb[1][7]}}, {8{bs_strb[1][6]}},
          {8{bs_strb[1][5]}}, {8{bs_strb[1][4]}}, {8{bs_strb[1][3]}}, {8{bs_strb[1][2]}},
          {8{bs_strb[1][1]}}, {8{bs_strb[1][0]}}});
      chk("model_abort_b2", 0, shadow[102], 64'h0);
      run_burst(1'b0, 100, 0, -1);
      run_burst(1'b0, 100, 2, -1);

      for (int n = 0; n < 40; n++) begin
         a   = ($urandom_range(0, 47) + DEPTH - 16) % DEPTH;
         len = $urandom_range(0, 15);
         rand_beats(len);
         run_burst(1'($urandom_range(0, 1)), a, len, -1);
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
